wb_port_arbiter: RTL and testbench



---
 rtl/wb_port_arbiter_pkg.sv | 14 +
 rtl/wb_port_arbiter_if.sv | 38 +++
 rtl/wb_port_arbiter_fifo.sv | 57 +++++
 rtl/wb_port_arbiter.sv | 107 ++++++++++
 tb/tb_wb_port_arbiter.sv | 223 ++++++++++++++++++++++
 5 files changed

// File: rtl/wb_port_arbiter_pkg.sv
// Shared types for the register-file write-port arbiter: register index and
// buffered long-latency result entry.
package wb_port_arbiter_pkg;
  localparam int XLEN  = 32;
  localparam int NREG  = 32;
  localparam int REG_W = $clog2(NREG);

  typedef logic [REG_W-1:0] reg_idx_t;

  typedef struct packed {
    reg_idx_t          rd;
    logic [XLEN-1:0]   wd;
  } wb_entry_t;
endpackage

// File: rtl/wb_port_arbiter_if.sv
// Bus bundle between writeback stage, multi-cycle unit, register file and the
// arbiter. The arbiter takes the slave modport.
interface wb_port_arbiter_if;
  import wb_port_arbiter_pkg::*;

  logic            pipe_we;
  reg_idx_t        pipe_rd;
  logic [XLEN-1:0] pipe_wd;
  logic            mc_issue;
  reg_idx_t        mc_issue_rd;
  logic            mc_valid;
  logic            mc_ready;
  reg_idx_t        mc_rd;
  logic [XLEN-1:0] mc_wd;
  logic            rf_we;
  reg_idx_t        rf_a3;
  logic [XLEN-1:0] rf_wd;
  logic [NREG-1:0] busy;
  logic            stall_req;

  modport master (
    output pipe_we, pipe_rd, pipe_wd,
    output mc_issue, mc_issue_rd,
    output mc_valid, mc_rd, mc_wd,
    input  mc_ready,
    input  rf_we, rf_a3, rf_wd,
    input  busy, stall_req
  );

  modport slave (
    input  pipe_we, pipe_rd, pipe_wd,
    input  mc_issue, mc_issue_rd,
    input  mc_valid, mc_rd, mc_wd,
    output mc_ready,
    output rf_we, rf_a3, rf_wd,
    output busy, stall_req
  );
endinterface

// File: rtl/wb_port_arbiter_fifo.sv
// Small synchronous FIFO of buffered long-latency results. The head is read
// combinationally so it can drain in the same cycle the port is free.
module wb_fifo
  import wb_port_arbiter_pkg::*;
#(
  parameter int DEPTH = 2
) (
  input  logic      clk,
  input  logic      reset,
  input  logic      push,
  input  wb_entry_t push_data,
  input  logic      pop,
  output wb_entry_t head,
  output logic      full,
  output logic      empty
);
  localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CNT_W = $clog2(DEPTH + 1);

  wb_entry_t        mem_q [DEPTH];
  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic             do_push, do_pop;

  assign full    = (count_q == CNT_W'(DEPTH));
  assign empty   = (count_q == '0);
  assign do_push = push && !full;
  assign do_pop  = pop && !empty;
  assign head    = mem_q[rd_ptr_q];

  // DEPTH is a power of two, so pointer overflow is the modulo wrap.
  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (do_push) wr_ptr_d = wr_ptr_q + PTR_W'(1);
    if (do_pop)  rd_ptr_d = rd_ptr_q + PTR_W'(1);
    count_d = count_q + CNT_W'(do_push) - CNT_W'(do_pop);
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem_q[wr_ptr_q] <= push_data;
  end
endmodule

// File: rtl/wb_port_arbiter.sv
// Single write-port arbiter: live pipeline writes win, buffered long-latency
// results fill idle slots, a starvation counter forces a bubble for the head.
module wb_port_arbiter #(
  parameter int XLEN       = 32,
  parameter int NREG       = 32,
  parameter int FIFO_DEPTH = 2,
  parameter int STARVE_MAX = 4
) (
  input  logic               clk,
  input  logic               reset,
  wb_port_arbiter_if.slave   bus
);
  import wb_port_arbiter_pkg::*;

  localparam int SW = $clog2(STARVE_MAX + 1);

  logic            pipe_live;
  logic            fifo_push, fifo_pop, fifo_full, fifo_empty;
  wb_entry_t       push_data, head;
  logic            rf_we_c;
  reg_idx_t        rf_a3_c;
  logic [XLEN-1:0] rf_wd_c;
  logic [NREG-1:0] busy_q, busy_d;
  logic [SW-1:0]   starve_q, starve_d;

  assign pipe_live = bus.pipe_we && (bus.pipe_rd != '0);
  // x0 results are acknowledged but never buffered.
  assign fifo_push = bus.mc_valid && !fifo_full && (bus.mc_rd != '0);
  assign push_data = '{rd: bus.mc_rd, wd: bus.mc_wd};

  wb_fifo #(.DEPTH(FIFO_DEPTH)) u_fifo (
    .clk       (clk),
    .reset     (reset),
    .push      (fifo_push),
    .push_data (push_data),
    .pop       (fifo_pop),
    .head      (head),
    .full      (fifo_full),
    .empty     (fifo_empty)
  );

  always_comb begin
    rf_we_c  = 1'b0;
    rf_a3_c  = '0;
    rf_wd_c  = '0;
    fifo_pop = 1'b0;
    if (pipe_live) begin
      rf_we_c = 1'b1;
      rf_a3_c = bus.pipe_rd;
      rf_wd_c = bus.pipe_wd;
    end else if (!fifo_empty) begin
      rf_we_c  = 1'b1;
      rf_a3_c  = head.rd;
      rf_wd_c  = head.wd;
      fifo_pop = 1'b1;
    end
  end

  assign bus.rf_we     = rf_we_c;
  assign bus.rf_a3     = rf_a3_c;
  assign bus.rf_wd     = rf_wd_c;
  assign bus.mc_ready  = !fifo_full;
  assign bus.busy      = busy_q;
  assign bus.stall_req = (starve_q == SW'(STARVE_MAX));

  // A bit clears on the edge its result is written and sets on issue.
  assign busy_d[0] = 1'b0;
  generate
    genvar gi;
    for (gi = 1; gi < NREG; gi++) begin : g_busy
      assign busy_d[gi] = (busy_q[gi] && !(fifo_pop && (head.rd == reg_idx_t'(gi))))
                        || (bus.mc_issue && (bus.mc_issue_rd == reg_idx_t'(gi)));
    end
  endgenerate

  always_comb begin
    starve_d = starve_q;
    if (fifo_empty || fifo_pop) begin
      starve_d = '0;
    end else if (starve_q != SW'(STARVE_MAX)) begin
      starve_d = starve_q + SW'(1);
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      busy_q   <= '0;
      starve_q <= '0;
    end else begin
      busy_q   <= busy_d;
      starve_q <= starve_d;
    end
  end

  // Protocol misuse by the pipeline or issue logic.
  always_ff @(posedge clk) begin
    if (!reset) begin
      if (bus.mc_issue && (bus.mc_issue_rd != '0)) begin
        a_issue_busy: assert (!busy_q[bus.mc_issue_rd]);
      end
      if (pipe_live) begin
        a_pipe_busy: assert (!busy_q[bus.pipe_rd]);
      end
      a_pipe_stall: assert (!(bus.pipe_we && bus.stall_req));
    end
  end
endmodule

// File: tb/tb_wb_port_arbiter.sv
// Directed scenarios followed by constrained-random traffic, every cycle checked
// against a queue-based model of the write-port rules.
module tb_wb_port_arbiter;
  import wb_port_arbiter_pkg::*;

  localparam int DEPTH = 2;
  localparam int SMAX  = 4;

  logic clk = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;

  wb_port_arbiter_if bus();

  wb_port_arbiter #(.XLEN(32), .NREG(32), .FIFO_DEPTH(DEPTH), .STARVE_MAX(SMAX)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  typedef struct {
    int          rd;
    logic [31:0] wd;
  } ent_t;

  int unsigned ncmp = 0;
  int unsigned nfail = 0;
  ent_t        mq[$];
  bit          mbusy[32];
  int          pend[$];
  int          cyc_n = 0;
  int          head_since = 0;
  logic        o_we, o_stall, o_ready;
  logic [4:0]  o_a3;
  logic [31:0] o_wd;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    ncmp++;
    assert (obs === exp) else begin
      nfail++;
      $error("FAIL %s: got %0h want %0h", tag, obs, exp);
    end
  endtask

  // The head has waited (cyc_n - head_since) cycles without being written.
  function automatic bit m_stall();
    return (mq.size() > 0) && ((cyc_n - head_since) == SMAX);
  endfunction

  function automatic logic [31:0] m_busy();
    logic [31:0] r;
    for (int i = 0; i < 32; i++) r[i] = mbusy[i];
    return r;
  endfunction

  task automatic model_reset();
    mq.delete();
    pend.delete();
    for (int i = 0; i < 32; i++) mbusy[i] = 1'b0;
    head_since = cyc_n;
  endtask

  task automatic drive(input bit pwe, input int prd, input logic [31:0] pwd,
                       input bit iss, input int ird,
                       input bit mv, input int mrd, input logic [31:0] mwd);
    bus.pipe_we     = pwe;
    bus.pipe_rd     = 5'(prd);
    bus.pipe_wd     = pwd;
    bus.mc_issue    = iss;
    bus.mc_issue_rd = 5'(ird);
    bus.mc_valid    = mv;
    bus.mc_rd       = 5'(mrd);
    bus.mc_wd       = mwd;
  endtask

  task automatic idle();
    drive(0, 0, 0, 0, 0, 0, 0, 0);
  endtask

  // Called just after a rising edge with inputs already set.
  task automatic cycle();
    bit          live, e_we, rdy;
    int          e_a3;
    logic [31:0] e_wd;
    live = bus.pipe_we && (bus.pipe_rd != 0);
    rdy  = mq.size() < DEPTH;
    e_we = live || (mq.size() > 0);
    e_a3 = live ? int'(bus.pipe_rd) : (mq.size() > 0 ? mq[0].rd : 0);
    e_wd = live ? bus.pipe_wd : (mq.size() > 0 ? mq[0].wd : 32'h0);
    @(negedge clk);
    chk("rf_we", bus.rf_we, e_we);
    if (e_we) begin
      chk("rf_a3", bus.rf_a3, e_a3);
      chk("rf_wd", bus.rf_wd, e_wd);
    end else begin
      chk("rf_known", $isunknown({bus.rf_a3, bus.rf_wd}), 0);
    end
    chk("mc_ready", bus.mc_ready, rdy);
    chk("stall_req", bus.stall_req, m_stall());
    chk("busy", bus.busy, m_busy());
    o_we = bus.rf_we; o_a3 = bus.rf_a3; o_wd = bus.rf_wd;
    o_stall = bus.stall_req; o_ready = bus.mc_ready;
    @(posedge clk);
    if (!live && mq.size() > 0) begin
      mbusy[mq[0].rd] = 1'b0;
      void'(mq.pop_front());
      head_since = cyc_n + 1;
    end
    if (bus.mc_valid && rdy && bus.mc_rd != 0) begin
      if (mq.size() == 0) head_since = cyc_n + 1;
      mq.push_back('{int'(bus.mc_rd), bus.mc_wd});
    end
    if (bus.mc_issue && bus.mc_issue_rd != 0) mbusy[bus.mc_issue_rd] = 1'b1;
    cyc_n++;
    #1;
  endtask

  initial begin
    idle();
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    chk("rst_busy", bus.busy, 0);
    chk("rst_ready", bus.mc_ready, 1);
    chk("rst_stall", bus.stall_req, 0);
    chk("rst_we", bus.rf_we, 0);
    reset = 1'b0;

    // Issue rd=7, result three cycles later on an idle port.
    drive(0, 0, 0, 1, 7, 0, 0, 0); cycle();
    chk("busy7_set", bus.busy[7], 1);
    idle(); cycle(); cycle();
    drive(0, 0, 0, 0, 0, 1, 7, 32'hDEADBEEF); cycle();
    idle(); cycle();
    chk("mc_we", o_we, 1);
    chk("mc_a3", o_a3, 7);
    chk("mc_wd", o_wd, 32'hDEADBEEF);
    chk("busy7_clr", bus.busy[7], 0);

    // Continuous pipeline writes to x3 starve a buffered rd=9.
    drive(0, 0, 0, 1, 9, 0, 0, 0); cycle();
    drive(1, 3, 32'h33, 0, 0, 1, 9, 32'h9999); cycle();
    for (int i = 1; i <= 6; i++) begin
      drive(!m_stall(), 3, $urandom, 0, 0, 0, 0, 0); cycle();
      chk($sformatf("starve_%0d", i), o_stall, (i == 5));
      if (i == 5) chk("starve_a3", o_a3, 9);
    end

    // Fill the FIFO behind pipeline writes, then bubble.
    drive(0, 0, 0, 1, 10, 0, 0, 0); cycle();
    drive(0, 0, 0, 1, 11, 0, 0, 0); cycle();
    drive(0, 0, 0, 1, 12, 0, 0, 0); cycle();
    drive(1, 3, 1, 0, 0, 1, 10, 32'hA0A0); cycle();
    drive(1, 3, 2, 0, 0, 1, 11, 32'hB1B1); cycle();
    drive(!m_stall(), 3, 3, 0, 0, 0, 0, 0); cycle();
    chk("full_ready", o_ready, 0);
    drive(0, 0, 0, 0, 0, 1, 12, 32'hC2C2); cycle();
    chk("full_pop_ready", o_ready, 0);
    drive(0, 0, 0, 0, 0, 1, 12, 32'hC2C2); cycle();
    chk("pop_push_ready", o_ready, 1);
    idle(); repeat (3) cycle();

    // x0 on both paths, then a head drains under an x0 pipeline write.
    drive(1, 0, 32'h1111, 0, 0, 1, 0, 32'h2222); cycle();
    chk("x0_we", o_we, 0);
    drive(0, 0, 0, 1, 13, 0, 0, 0); cycle();
    drive(1, 3, 4, 0, 0, 1, 13, 32'h1313); cycle();
    drive(1, 0, 5, 0, 0, 0, 0, 0); cycle();
    chk("x0_drain_we", o_we, 1);
    chk("x0_drain_a3", o_a3, 13);

    // Asynchronous reset with two results buffered and x5 outstanding.
    drive(0, 0, 0, 1, 5, 0, 0, 0); cycle();
    drive(0, 0, 0, 1, 14, 0, 0, 0); cycle();
    drive(0, 0, 0, 1, 15, 0, 0, 0); cycle();
    drive(1, 3, 6, 0, 0, 1, 14, 32'h1414); cycle();
    drive(1, 3, 7, 0, 0, 1, 15, 32'h1515); cycle();
    chk("pre_rst_busy5", bus.busy[5], 1);
    chk("pre_rst_full", bus.mc_ready, 0);
    idle();
    #2 reset = 1'b1;
    #1;
    chk("arst_busy", bus.busy, 0);
    chk("arst_ready", bus.mc_ready, 1);
    chk("arst_stall", bus.stall_req, 0);
    chk("arst_we", bus.rf_we, 0);
    model_reset();
    @(posedge clk);
    #1 reset = 1'b0;
    for (int i = 0; i < 3; i++) begin
      cycle();
      chk("post_rst_we", o_we, 0);
    end

    // Constrained-random traffic obeying the hazard rules.
    for (int n = 0; n < 1500; n++) begin
      bit pwe, iss, mv, rdy;
      int prd, ird, mrd;
      pwe = 0; iss = 0; mv = 0; prd = 0; ird = 0; mrd = 0;
      rdy = mq.size() < DEPTH;
      if (!m_stall() && $urandom_range(0, 9) < 6) begin
        prd = $urandom_range(0, 31);
        pwe = !mbusy[prd];
      end
      if ($urandom_range(0, 9) < 3) begin
        ird = $urandom_range(0, 31);
        iss = !mbusy[ird];
      end
      if (pend.size() > 0 && $urandom_range(0, 9) < 5) begin
        mv = 1; mrd = pend[0];
      end else if ($urandom_range(0, 19) == 0) begin
        mv = 1; mrd = 0;
      end
      drive(pwe, prd, $urandom, iss, ird, mv, mrd, $urandom);
      cycle();
      if (mv && mrd != 0 && rdy) void'(pend.pop_front());
      if (iss && ird != 0) pend.push_back(ird);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncmp, nfail);
    $finish;
  end
endmodule
